// File: rtl/pp3_logic_cfg_loader_if.sv
// Bus bundle between the configuration port and the PP3 config loader.
//   Serial side : sdi (data bit, MSB first), sen (bit qualifier),
//                 abort (drop partial frame), errclr (clear sticky error)
//   Config side : cfg_we (write strobe), cfg_addr (cell address),
//                 cfg_data (cell control bits), busy, err, errcode, fcnt
// The loader uses the slave modport; the configuration source and its
// observers use the master modport.
interface pp3_logic_cfg_loader_if;
   logic       sdi;
   logic       sen;
   logic       abort;
   logic       errclr;
   logic       cfg_we;
   logic [7:0] cfg_addr;
   logic [8:0] cfg_data;
   logic       busy;
   logic       err;
   logic [1:0] errcode;
   logic [7:0] fcnt;

   modport slave (
      input  sdi, sen, abort, errclr,
      output cfg_we, cfg_addr, cfg_data, busy, err, errcode, fcnt
   );

   modport master (
      output sdi, sen, abort, errclr,
      input  cfg_we, cfg_addr, cfg_data, busy, err, errcode, fcnt
   );
endinterface

// File: rtl/pp3_logic_cfg_loader.sv
// Serial configuration writer for the PP3 logic-cell array.
// Hunts for a sync byte in the qualified bit stream (bit-sliding, no byte
// alignment), then collects ADDR(8), DATA(16) and CHK(8). One CHECK cycle
// validates checksum, address range and reserved bits; a good frame produces
// a single-cycle cfg_we with cfg_addr/cfg_data, a bad frame only latches the
// first error cause.
// Ports:
//   qck  - clock, rising edge
//   qrn  - asynchronous active-low reset
//   bus  - pp3_logic_cfg_loader_if.slave (serial in, config write out, status)
// cfg_data map: [0]TAS1 [1]TAS2 [2]TBS1 [3]TBS2 [4]BAS1 [5]BAS2 [6]BBS1
//               [7]BBS2 [8]Z_QCKS
//
// state   | meaning
// --------+------------------------------------------------------------
// S_HUNT  | sliding search for SYNC in the qualified bit stream
// S_ADDR  | shifting in 8 address bits
// S_DATA  | shifting in 16 data bits
// S_CHK   | shifting in 8 checksum bits
// S_CHECK | one-cycle validation; commit or flag error, then back to hunt
module pp3_logic_cfg_loader #(
   parameter int          NCELLS = 64,
   parameter logic [7:0]  SYNC   = 8'hA5
) (
   input  logic                      qck,
   input  logic                      qrn,
   pp3_logic_cfg_loader_if.slave     bus
);

   typedef enum logic [2:0] {
      S_HUNT  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_CHK   = 3'd3,
      S_CHECK = 3'd4
   } state_t;

   localparam logic [8:0] NCELLS_LIM = 9'(NCELLS);

   state_t      state, state_d;
   logic [4:0]  cnt, cnt_d;
   logic [7:0]  sync_sr, sync_d;
   logic [31:0] frame_sr, frame_d;
   logic [7:0]  sync_shift;

   logic [7:0]  f_addr;
   logic [15:0] f_data;
   logic [7:0]  f_chk;
   logic        chk_bad, addr_bad, rsv_bad;
   logic [1:0]  code_new;
   logic        commit, fail;

   // Frame fields once all 32 post-sync bits are in: {ADDR, DATA, CHK}.
   assign f_addr = frame_sr[31:24];
   assign f_data = frame_sr[23:8];
   assign f_chk  = frame_sr[7:0];

   assign chk_bad  = (f_addr ^ f_data[15:8] ^ f_data[7:0] ^ 8'hFF) != f_chk;
   assign addr_bad = {1'b0, f_addr} >= NCELLS_LIM;
   assign rsv_bad  = f_data[15:9] != 7'd0;

   // Checksum failure masks the other causes; address beats reserved bits.
   assign code_new = chk_bad  ? 2'b01 :
                     addr_bad ? 2'b10 : 2'b11;

   assign sync_shift = {sync_sr[6:0], bus.sdi};

   assign bus.busy = (state != S_HUNT);

   always_ff @(posedge qck or negedge qrn) begin
      if (!qrn) begin
         state    <= S_HUNT;
         cnt      <= 5'd0;
         sync_sr  <= 8'd0;
         frame_sr <= 32'd0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         sync_sr  <= sync_d;
         frame_sr <= frame_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sync_d  = sync_sr;
      frame_d = frame_sr;
      commit  = 1'b0;
      fail    = 1'b0;

      case (state)
         S_HUNT: begin
            // The commit cycle (cfg_we high) is already back in hunt but must
            // not consume a bit, so the search is gated by cfg_we.
            if (bus.sen && !bus.cfg_we) begin
               sync_d = sync_shift;
               if (sync_shift == SYNC) begin
                  state_d = S_ADDR;
                  cnt_d   = 5'd0;
               end
            end
         end
         S_ADDR: begin
            if (bus.sen) begin
               frame_d = {frame_sr[30:0], bus.sdi};
               if (cnt == 5'd7) begin
                  state_d = S_DATA;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d = cnt + 5'd1;
               end
            end
         end
         S_DATA: begin
            if (bus.sen) begin
               frame_d = {frame_sr[30:0], bus.sdi};
               if (cnt == 5'd15) begin
                  state_d = S_CHK;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d = cnt + 5'd1;
               end
            end
         end
         S_CHK: begin
            if (bus.sen) begin
               frame_d = {frame_sr[30:0], bus.sdi};
               if (cnt == 5'd7) begin
                  state_d = S_CHECK;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d = cnt + 5'd1;
               end
            end
         end
         S_CHECK: begin
            state_d = S_HUNT;
            sync_d  = 8'd0;
            if (!chk_bad && !addr_bad && !rsv_bad) begin
               commit = 1'b1;
            end else begin
               fail = 1'b1;
            end
         end
         default: begin
            state_d = S_HUNT;
            cnt_d   = 5'd0;
            sync_d  = 8'd0;
         end
      endcase

      if (bus.abort) begin
         state_d = S_HUNT;
         cnt_d   = 5'd0;
         sync_d  = 8'd0;
         commit  = 1'b0;
         fail    = 1'b0;
      end
   end

   always_ff @(posedge qck or negedge qrn) begin
      if (!qrn) begin
         bus.cfg_we   <= 1'b0;
         bus.cfg_addr <= 8'd0;
         bus.cfg_data <= 9'h100;
         bus.fcnt     <= 8'd0;
      end else begin
         bus.cfg_we <= commit;
         if (commit) begin
            bus.cfg_addr <= f_addr;
            bus.cfg_data <= f_data[8:0];
            bus.fcnt     <= bus.fcnt + 8'd1;
         end
      end
   end

   // A new error overrides a same-cycle clear, even when err is already set.
   always_ff @(posedge qck or negedge qrn) begin
      if (!qrn) begin
         bus.err     <= 1'b0;
         bus.errcode <= 2'b00;
      end else if (fail && (!bus.err || bus.errclr)) begin
         bus.err     <= 1'b1;
         bus.errcode <= code_new;
      end else if (bus.errclr) begin
         bus.err     <= 1'b0;
         bus.errcode <= 2'b00;
      end
   end

endmodule

// File: tb/tb_pp3_logic_cfg_loader.sv
module tb_pp3_logic_cfg_loader;

   logic qck = 1'b0;
   logic qrn = 1'b0;
   always #5 qck = ~qck;

   pp3_logic_cfg_loader_if bus ();

   pp3_logic_cfg_loader #(.NCELLS(64), .SYNC(8'hA5)) dut (
      .qck (qck),
      .qrn (qrn),
      .bus (bus)
   );

   int ntests = 0;
   int nfail  = 0;
   int wr_cnt = 0;
   int base;
   logic [39:0] fr;
   logic [7:0]  a, c;
   logic [15:0] d;

   always @(negedge qck) if (bus.cfg_we === 1'b1) wr_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge qck);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [39:0] v, input int n, input bit toggle);
      for (int i = n - 1; i >= 0; i--) begin
         if (toggle) begin
            bus.sen = 1'b0;
            tick();
         end
         bus.sdi = v[i];
         bus.sen = 1'b1;
         tick();
      end
      bus.sen = 1'b0;
      bus.sdi = 1'b0;
   endtask

   initial begin
      bus.sdi = 1'b0; bus.sen = 1'b0; bus.abort = 1'b0; bus.errclr = 1'b0;
      tick(); tick();
      check("rst_we",      32'(bus.cfg_we),   32'h0);
      check("rst_addr",    32'(bus.cfg_addr), 32'h0);
      check("rst_data",    32'(bus.cfg_data), 32'h100);
      check("rst_busy",    32'(bus.busy),     32'h0);
      check("rst_err",     32'(bus.err),      32'h0);
      check("rst_errcode", 32'(bus.errcode),  32'h0);
      check("rst_fcnt",    32'(bus.fcnt),     32'h0);
      qrn = 1'b1;
      tick();

      // good frame, continuous sen
      send_bits(40'hA5_05_0103_F8, 40, 1'b0);
      check("g1_check_busy", 32'(bus.busy),   32'h1);
      check("g1_check_we",   32'(bus.cfg_we), 32'h0);
      tick();
      check("g1_we",   32'(bus.cfg_we),   32'h1);
      check("g1_addr", 32'(bus.cfg_addr), 32'h05);
      check("g1_data", 32'(bus.cfg_data), 32'h103);
      check("g1_fcnt", 32'(bus.fcnt),     32'h1);
      check("g1_busy", 32'(bus.busy),     32'h0);
      check("g1_err",  32'(bus.err),      32'h0);
      tick();
      check("g1_we_pulse", 32'(bus.cfg_we), 32'h0);
      check("g1_wrcnt",    32'(wr_cnt),     32'd1);

      // junk bits then the same frame with sen toggling
      send_bits(40'b101, 3, 1'b1);
      send_bits(40'hA5_05_0103_F8, 40, 1'b1);
      tick();
      check("g2_we",   32'(bus.cfg_we),   32'h1);
      check("g2_addr", 32'(bus.cfg_addr), 32'h05);
      check("g2_data", 32'(bus.cfg_data), 32'h103);
      check("g2_fcnt", 32'(bus.fcnt),     32'h2);
      tick();

      // bad checksum
      send_bits(40'hA5_05_0103_F9, 40, 1'b0);
      tick();
      check("bc_we",      32'(bus.cfg_we),  32'h0);
      check("bc_err",     32'(bus.err),     32'h1);
      check("bc_errcode", 32'(bus.errcode), 32'h1);
      tick();
      check("bc_wrcnt", 32'(wr_cnt),   32'd2);
      check("bc_fcnt",  32'(bus.fcnt), 32'h2);
      bus.errclr = 1'b1; tick(); bus.errclr = 1'b0;
      check("clr_err",     32'(bus.err),     32'h0);
      check("clr_errcode", 32'(bus.errcode), 32'h0);
      send_bits(40'hA5_05_0103_F8, 40, 1'b0);
      tick();
      check("g3_we",   32'(bus.cfg_we), 32'h1);
      check("g3_fcnt", 32'(bus.fcnt),   32'h3);
      tick();

      // address out of range, then reserved-bit frame keeps first code
      send_bits(40'hA5_40_0001_BE, 40, 1'b0);
      tick();
      check("ar_we",      32'(bus.cfg_we),  32'h0);
      check("ar_err",     32'(bus.err),     32'h1);
      check("ar_errcode", 32'(bus.errcode), 32'h2);
      tick();
      send_bits(40'hA5_01_0200_FC, 40, 1'b0);
      tick();
      check("rs_we",      32'(bus.cfg_we),  32'h0);
      check("rs_errcode", 32'(bus.errcode), 32'h2);
      tick();
      // errclr in the same cycle as a new error: new error wins
      send_bits(40'hA5_01_0200_FC, 40, 1'b0);
      bus.errclr = 1'b1; tick(); bus.errclr = 1'b0;
      check("ce_err",     32'(bus.err),     32'h1);
      check("ce_errcode", 32'(bus.errcode), 32'h3);
      tick();
      bus.errclr = 1'b1; tick(); bus.errclr = 1'b0;
      // bad checksum and bad address: checksum reported
      send_bits(40'hA5_40_0001_BF, 40, 1'b0);
      tick();
      check("pr_errcode", 32'(bus.errcode), 32'h1);
      tick();
      check("pr_wrcnt", 32'(wr_cnt), 32'd3);
      bus.errclr = 1'b1; tick(); bus.errclr = 1'b0;

      // abort during DATA bit 7, then a full good frame
      send_bits(40'h00_00_A5_3F_00 >> 1, 23, 1'b0);
      check("ab_busy_pre", 32'(bus.busy), 32'h1);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("ab_busy", 32'(bus.busy), 32'h0);
      send_bits(40'hA5_3F_01FF_3E, 40, 1'b0);
      tick();
      check("ab_we",   32'(bus.cfg_we),   32'h1);
      check("ab_addr", 32'(bus.cfg_addr), 32'h3F);
      check("ab_data", 32'(bus.cfg_data), 32'h1FF);
      tick();
      check("ab_wrcnt", 32'(wr_cnt), 32'd4);

      // abort in the CHECK cycle suppresses the write
      send_bits(40'hA5_05_0103_F8, 40, 1'b0);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("abc_we",   32'(bus.cfg_we), 32'h0);
      check("abc_busy", 32'(bus.busy),   32'h0);
      tick();
      check("abc_wrcnt", 32'(wr_cnt),   32'd4);
      check("abc_fcnt",  32'(bus.fcnt), 32'h4);

      // async reset in the middle of CHK
      send_bits(40'hA5_05_0103_F8 >> 4, 36, 1'b0);
      check("rm_busy_pre", 32'(bus.busy), 32'h1);
      #1 qrn = 1'b0;
      #1;
      check("rm_addr", 32'(bus.cfg_addr), 32'h0);
      check("rm_data", 32'(bus.cfg_data), 32'h100);
      check("rm_fcnt", 32'(bus.fcnt),     32'h0);
      check("rm_busy", 32'(bus.busy),     32'h0);
      check("rm_we",   32'(bus.cfg_we),   32'h0);
      #1 qrn = 1'b1;
      tick(); tick();
      check("rm_wrcnt", 32'(wr_cnt), 32'd4);

      // 256 good frames, fcnt wraps
      base = wr_cnt;
      for (int i = 0; i < 256; i++) begin
         a  = 8'(i % 64);
         d  = {7'd0, ~i[0], 8'(i)};
         c  = a ^ d[15:8] ^ d[7:0] ^ 8'hFF;
         fr = {8'hA5, a, d, c};
         send_bits(fr, 40, 1'b0);
         tick(); tick();
         if (i == 254) check("wrap_fcnt_255", 32'(bus.fcnt), 32'hFF);
      end
      check("wrap_fcnt_0", 32'(bus.fcnt),     32'h0);
      check("wrap_addr",   32'(bus.cfg_addr), 32'h3F);
      check("wrap_data",   32'(bus.cfg_data), 32'h0FF);
      check("wrap_wrcnt",  32'(wr_cnt - base), 32'd256);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
